// File: rtl/rw_window_seq.sv
// Framed bus-access sequencer: start, one write, programmable gap, RD_LAT read cycles, stop.
// Also captures read data and counts completed (non-aborted) transactions.
module rw_window_seq #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int GAP_W  = 4,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic              abort,
    output logic              start,
    output logic              wr,
    output logic              rd,
    output logic              stop,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rdata_vld,
    output logic              done,
    output logic              err,
    output logic [15:0]       txn_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WR,
        S_GAP,
        S_RD,
        S_STOP
    } state_t;

    localparam logic [3:0]       RD_LOAD = 4'(RD_LAT);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_ZERO = '0;

    state_t           state;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       rd_cnt;

    // Outputs are computed from the next state so every strobe is a flop
    // that lines up exactly with the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            start     <= 1'b0;
            wr        <= 1'b0;
            rd        <= 1'b0;
            stop      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata_vld <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rdata_out <= '0;
            txn_cnt   <= '0;
            gap_cnt   <= '0;
            rd_cnt    <= '0;
        end else begin
            req_ready <= 1'b0;
            start     <= 1'b0;
            wr        <= 1'b0;
            rd        <= 1'b0;
            stop      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata_vld <= 1'b0;

            if (abort && (state inside {S_START, S_WR, S_GAP, S_RD})) begin
                // Aborted windows still close with a stop so the checker sees a framed access.
                state <= S_STOP;
                stop  <= 1'b1;
                done  <= 1'b1;
                err   <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (req && req_ready) begin
                            addr    <= req_addr;
                            wdata   <= req_wdata;
                            gap_cnt <= cfg_gap;
                            rd_cnt  <= RD_LOAD;
                            state   <= S_START;
                            start   <= 1'b1;
                        end else begin
                            req_ready <= 1'b1;
                        end
                    end
                    S_START: begin
                        state <= S_WR;
                        wr    <= 1'b1;
                    end
                    S_WR: begin
                        if (gap_cnt != GAP_ZERO) begin
                            state <= S_GAP;
                        end else begin
                            state <= S_RD;
                            rd    <= 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == GAP_ONE) begin
                            state <= S_RD;
                            rd    <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - GAP_ONE;
                        end
                    end
                    S_RD: begin
                        if (rd_cnt == 4'd1) begin
                            state     <= S_STOP;
                            stop      <= 1'b1;
                            done      <= 1'b1;
                            rdata_vld <= 1'b1;
                            rdata_out <= rdata;
                            txn_cnt   <= txn_cnt + 16'd1;
                        end else begin
                            rd_cnt <= rd_cnt - 4'd1;
                            rd     <= 1'b1;
                        end
                    end
                    S_STOP: begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end
                    default: begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rw_window_seq.sv
// Directed bench for rw_window_seq: cycle-by-cycle vector table plus hand-written
// sequences for back-to-back, mid-transaction reset and counter wrap.
module tb_rw_window_seq;

    localparam int RD_LAT = 2;

    localparam logic [7:0] F_RDY   = 8'h80;
    localparam logic [7:0] F_START = 8'h40;
    localparam logic [7:0] F_WR    = 8'h20;
    localparam logic [7:0] F_RD    = 8'h10;
    localparam logic [7:0] F_STOP  = 8'h08;
    localparam logic [7:0] F_DONE  = 8'h04;
    localparam logic [7:0] F_ERR   = 8'h02;
    localparam logic [7:0] F_VLD   = 8'h01;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        req_ready;
    logic [7:0]  req_addr;
    logic [7:0]  req_wdata;
    logic [3:0]  cfg_gap;
    logic        abort;
    logic        start, wr, rd, stop;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [7:0]  rdata_out;
    logic        rdata_vld;
    logic        done;
    logic        err;
    logic [15:0] txn_cnt;

    int checks = 0;
    int failures = 0;

    rw_window_seq #(
        .ADDR_W(8),
        .DATA_W(8),
        .GAP_W (4),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .cfg_gap  (cfg_gap),
        .abort    (abort),
        .start    (start),
        .wr       (wr),
        .rd       (rd),
        .stop     (stop),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rdata_out(rdata_out),
        .rdata_vld(rdata_vld),
        .done     (done),
        .err      (err),
        .txn_cnt  (txn_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        abort;
        logic [7:0]  addr_in;
        logic [7:0]  wdata_in;
        logic [7:0]  rdata_in;
        logic [3:0]  gap_in;
        logic [7:0]  exp_flags;
        logic [7:0]  exp_addr;
        logic [7:0]  exp_wdata;
        logic [7:0]  exp_rdata_out;
        logic [15:0] exp_txn;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic ab, logic [7:0] a, logic [7:0] wd,
                                logic [7:0] rdi, logic [3:0] g, logic [7:0] f,
                                logic [7:0] ea, logic [7:0] ewd, logic [7:0] ero,
                                logic [15:0] et);
        vec_t v;
        v.req = r; v.abort = ab; v.addr_in = a; v.wdata_in = wd; v.rdata_in = rdi;
        v.gap_in = g; v.exp_flags = f; v.exp_addr = ea; v.exp_wdata = ewd;
        v.exp_rdata_out = ero; v.exp_txn = et;
        return v;
    endfunction

    function automatic logic [7:0] flags();
        return {req_ready, start, wr, rd, stop, done, err, rdata_vld};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req       = v.req;
        abort     = v.abort;
        req_addr  = v.addr_in;
        req_wdata = v.wdata_in;
        rdata     = v.rdata_in;
        cfg_gap   = v.gap_in;
        tick();
    endtask

    task automatic checkVector(input int i, input vec_t v);
        checkOutput($sformatf("vec%0d flags", i), 32'(flags()), 32'(v.exp_flags));
        checkOutput($sformatf("vec%0d addr", i), 32'(addr), 32'(v.exp_addr));
        checkOutput($sformatf("vec%0d wdata", i), 32'(wdata), 32'(v.exp_wdata));
        checkOutput($sformatf("vec%0d rdata_out", i), 32'(rdata_out), 32'(v.exp_rdata_out));
        checkOutput($sformatf("vec%0d txn_cnt", i), 32'(txn_cnt), 32'(v.exp_txn));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " flags"}, 32'(flags()), 32'(F_RDY));
        checkOutput({tag, " addr"}, 32'(addr), 32'd0);
        checkOutput({tag, " wdata"}, 32'(wdata), 32'd0);
        checkOutput({tag, " rdata_out"}, 32'(rdata_out), 32'd0);
        checkOutput({tag, " txn_cnt"}, 32'(txn_cnt), 32'd0);
    endtask

    // Independent framing monitor: every non-aborted window holds exactly one wr
    // and RD_LAT rd cycles; stop only closes an open window and never meets start.
    int in_win = 0;
    int wr_n = 0;
    int rd_n = 0;
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            in_win = 0;
        end else begin
            if (stop) begin
                checkOutput("window stop inside window", 32'(in_win), 32'd1);
                checkOutput("window start/stop overlap", 32'(start), 32'd0);
            end
            if (start) begin
                in_win = 1;
                wr_n = 0;
                rd_n = 0;
            end else if (in_win != 0) begin
                if (wr) wr_n++;
                if (rd) rd_n++;
                if (stop) begin
                    in_win = 0;
                    if (!err) begin
                        checkOutput("window wr count", 32'(wr_n), 32'd1);
                        checkOutput("window rd count", 32'(rd_n), 32'(RD_LAT));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] start_mask;
        int overlap;
        int stop_seen;
        int stop_cyc;
        logic [7:0] ro_at_stop;
        logic [15:0] txn_at_stop;
        logic vld_at_stop;
        logic err_at_stop;

        // Gap 0 transaction, addr 0x12 / wdata 0xA5 / rdata 0x3C.
        vecs.push_back(mk(1, 0, 8'h12, 8'hA5, 8'h3C, 4'd0, F_START, 8'h12, 8'hA5, 8'h00, 16'd0));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h3C, 4'd0, F_WR,    8'h12, 8'hA5, 8'h00, 16'd0));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h3C, 4'd0, F_RD,    8'h12, 8'hA5, 8'h00, 16'd0));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h3C, 4'd0, F_RD,    8'h12, 8'hA5, 8'h00, 16'd0));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h3C, 4'd0, F_STOP | F_DONE | F_VLD, 8'h12, 8'hA5, 8'h3C, 16'd1));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h3C, 4'd0, F_RDY,   8'h12, 8'hA5, 8'h3C, 16'd1));
        // Gap 3 transaction: rd in c6-c7, stop in c8.
        vecs.push_back(mk(1, 0, 8'h34, 8'h5A, 8'h77, 4'd3, F_START, 8'h34, 8'h5A, 8'h3C, 16'd1));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h77, 4'd0, F_WR,    8'h34, 8'h5A, 8'h3C, 16'd1));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h77, 4'd0, 8'h00,   8'h34, 8'h5A, 8'h3C, 16'd1));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h77, 4'd0, 8'h00,   8'h34, 8'h5A, 8'h3C, 16'd1));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h77, 4'd0, 8'h00,   8'h34, 8'h5A, 8'h3C, 16'd1));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h77, 4'd0, F_RD,    8'h34, 8'h5A, 8'h3C, 16'd1));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h77, 4'd0, F_RD,    8'h34, 8'h5A, 8'h3C, 16'd1));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h77, 4'd0, F_STOP | F_DONE | F_VLD, 8'h34, 8'h5A, 8'h77, 16'd2));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h77, 4'd0, F_RDY,   8'h34, 8'h5A, 8'h77, 16'd2));
        // Abort in first rd cycle; a req pulsed in c2 must be ignored.
        vecs.push_back(mk(1, 0, 8'h56, 8'h65, 8'h99, 4'd0, F_START, 8'h56, 8'h65, 8'h77, 16'd2));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h99, 4'd0, F_WR,    8'h56, 8'h65, 8'h77, 16'd2));
        vecs.push_back(mk(1, 0, 8'hEE, 8'hEE, 8'h99, 4'd5, F_RD,    8'h56, 8'h65, 8'h77, 16'd2));
        vecs.push_back(mk(0, 1, 8'h00, 8'h00, 8'h99, 4'd0, F_STOP | F_DONE | F_ERR, 8'h56, 8'h65, 8'h77, 16'd2));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h99, 4'd0, F_RDY,   8'h56, 8'h65, 8'h77, 16'd2));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h99, 4'd0, F_RDY,   8'h56, 8'h65, 8'h77, 16'd2));

        rst_n = 1'b0; req = 1'b0; abort = 1'b0;
        req_addr = '0; req_wdata = '0; cfg_gap = '0; rdata = '0;
        tick();
        tick();
        checkResetValues("reset");
        rst_n = 1'b1;
        tick();
        checkResetValues("idle after reset");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkVector(i, vecs[i]);
        end

        // Back-to-back with req held: starts in c1, c7, c13.
        req_addr = 8'h20; req_wdata = 8'h21; cfg_gap = 4'd0; rdata = 8'h11;
        start_mask = '0;
        overlap = 0;
        for (int k = 0; k < 20; k++) begin
            req = (k <= 12);
            tick();
            if (start) start_mask[k + 1] = 1'b1;
            if (start && stop) overlap++;
        end
        checkOutput("b2b start cycles", start_mask, 32'h0000_2082);
        checkOutput("b2b overlap", 32'(overlap), 32'd0);
        checkOutput("b2b txn_cnt", 32'(txn_cnt), 32'd5);
        checkOutput("b2b rdata_out", 32'(rdata_out), 32'h11);
        checkOutput("b2b req_ready", 32'(req_ready), 32'd1);

        // Reset asserted in c3 of a transaction.
        req_addr = 8'h78; req_wdata = 8'h87; cfg_gap = 4'd0; rdata = 8'hCC;
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checkResetValues("mid reset");
        rst_n = 1'b1;
        stop_seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (stop) stop_seen++;
        end
        checkOutput("mid reset no stop", 32'(stop_seen), 32'd0);

        // Fresh transaction after reset, gap 1: stop expected in c6.
        req_addr = 8'h9A; req_wdata = 8'hA9; cfg_gap = 4'd1; rdata = 8'h42;
        req = 1'b1;
        stop_cyc = -1;
        ro_at_stop = '0; txn_at_stop = '0; vld_at_stop = 1'b0; err_at_stop = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            req = 1'b0;
            if (stop && stop_cyc < 0) begin
                stop_cyc = k;
                ro_at_stop = rdata_out;
                txn_at_stop = txn_cnt;
                vld_at_stop = rdata_vld;
                err_at_stop = err;
            end
        end
        checkOutput("post reset stop cycle", 32'(stop_cyc), 32'd6);
        checkOutput("post reset rdata_out", 32'(ro_at_stop), 32'h42);
        checkOutput("post reset txn_cnt", 32'(txn_at_stop), 32'd1);
        checkOutput("post reset rdata_vld", 32'(vld_at_stop), 32'd1);
        checkOutput("post reset err", 32'(err_at_stop), 32'd0);

        // Counter wrap: preload 0xFFFF while idle, then complete one transaction.
        force dut.txn_cnt = 16'hFFFF;
        tick();
        release dut.txn_cnt;
        tick();
        checkOutput("wrap preload", 32'(txn_cnt), 32'hFFFF);
        req_addr = 8'h01; req_wdata = 8'h02; cfg_gap = 4'd0; rdata = 8'h5E;
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int k = 2; k <= 5; k++) tick();
        checkOutput("wrap flags", 32'(flags()), 32'(F_STOP | F_DONE | F_VLD));
        checkOutput("wrap txn_cnt", 32'(txn_cnt), 32'd0);
        checkOutput("wrap rdata_out", 32'(rdata_out), 32'h5E);
        tick();
        checkOutput("wrap ready", 32'(flags()), 32'(F_RDY));

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
